// File: rtl/i2c_eeprom_slave_if.sv
// I2C pin bundle between a bus master and the EEPROM responder.
// SDA_IN is the resolved pin level; SDA_OE is the responder's open-drain pull-down.
interface i2c_eeprom_slave_if;
  logic SCL;
  logic SDA_IN;
  logic SDA_OE;

  modport master (output SCL, output SDA_IN, input SDA_OE);
  modport slave  (input SCL, input SDA_IN, output SDA_OE);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// 24xx-style serial EEPROM responder: byte/sequential writes, random and
// current-address reads, bus sampled by CLK (no clock stretching).
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR  = 7'h50,
  parameter int         ADDR_BITS = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  i2c_eeprom_slave_if.slave    bus,
  input  logic [ADDR_BITS-1:0] DBG_ADDR,
  output logic [7:0]           DBG_DATA,
  output logic [ADDR_BITS-1:0] PTR,
  output logic                 BUSY,
  output logic                 WR_STROBE,
  output logic                 RD_STROBE
);
  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_DEVADDR  = 4'd1;
  localparam logic [3:0] S_DEVACK   = 4'd2;
  localparam logic [3:0] S_WORDADDR = 4'd3;
  localparam logic [3:0] S_WORDACK  = 4'd4;
  localparam logic [3:0] S_WRDATA   = 4'd5;
  localparam logic [3:0] S_WRACK    = 4'd6;
  localparam logic [3:0] S_RDDATA   = 4'd7;
  localparam logic [3:0] S_RDACK    = 4'd8;
  localparam logic [3:0] S_WAITSTOP = 4'd9;

  logic                 r_scl_s1, r_scl_s2, r_scl_d;
  logic                 r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0]           r_state;
  logic [3:0]           r_bit_cnt;
  logic [6:0]           r_shift;
  logic [7:0]           r_tx;
  logic                 r_rw;
  logic                 r_sda_oe;
  logic                 r_busy;
  logic                 r_wr_strobe;
  logic                 r_rd_strobe;
  logic [ADDR_BITS-1:0] r_ptr;
  logic [7:0]           r_mem [DEPTH];

  logic                 w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]           w_byte;
  logic [ADDR_BITS-1:0] w_ptr_inc;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift, r_sda_s2};
  assign w_ptr_inc  = r_ptr + ADDR_BITS'(1);

  assign bus.SDA_OE = r_sda_oe;
  assign DBG_DATA   = r_mem[DBG_ADDR];
  assign PTR        = r_ptr;
  assign BUSY       = r_busy;
  assign WR_STROBE  = r_wr_strobe;
  assign RD_STROBE  = r_rd_strobe;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      // Synchronizers rest at the idle bus level so release never fakes an event
      r_scl_s1    <= 1'b1;
      r_scl_s2    <= 1'b1;
      r_scl_d     <= 1'b1;
      r_sda_s1    <= 1'b1;
      r_sda_s2    <= 1'b1;
      r_sda_d     <= 1'b1;
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_tx        <= '0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_ptr       <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_scl_s1    <= bus.SCL;
      r_scl_s2    <= r_scl_s1;
      r_scl_d     <= r_scl_s2;
      r_sda_s1    <= bus.SDA_IN;
      r_sda_s2    <= r_sda_s1;
      r_sda_d     <= r_sda_s2;
      r_wr_strobe <= 1'b0;
      r_rd_strobe <= 1'b0;

      if (w_stop) begin
        r_state   <= S_IDLE;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= '0;
      end else if (w_start) begin
        r_state   <= S_DEVADDR;
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          S_DEVADDR, S_WORDADDR, S_WRDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                if (r_state == S_DEVADDR) begin
                  if (w_byte[7:1] == DEV_ADDR) begin
                    r_state <= S_DEVACK;
                    r_rw    <= w_byte[0];
                    r_busy  <= 1'b1;
                  end else begin
                    r_state <= S_WAITSTOP;
                    r_busy  <= 1'b0;
                  end
                end else if (r_state == S_WORDADDR) begin
                  r_ptr   <= w_byte[7 -: ADDR_BITS];
                  r_state <= S_WORDACK;
                end else begin
                  r_mem[r_ptr] <= w_byte;
                  r_wr_strobe  <= 1'b1;
                  r_ptr        <= w_ptr_inc;
                  r_state      <= S_WRACK;
                end
              end
            end
          end
          // First SCL fall drives the ACK low, the second ends it
          S_DEVACK, S_WORDACK, S_WRACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
                if (r_state == S_DEVACK && r_rw) begin
                  r_tx        <= r_mem[r_ptr];
                  r_rd_strobe <= 1'b1;
                end
              end else if (r_state == S_DEVACK && r_rw) begin
                r_sda_oe  <= ~r_tx[7];
                r_tx      <= {r_tx[6:0], 1'b0};
                r_bit_cnt <= 4'd1;
                r_state   <= S_RDDATA;
              end else begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= (r_state == S_DEVACK) ? S_WORDADDR : S_WRDATA;
              end
            end
          end
          S_RDDATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= S_RDACK;
              end else begin
                r_sda_oe  <= ~r_tx[7];
                r_tx      <= {r_tx[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_RDACK: begin
            if (w_scl_rise) begin
              r_ptr <= w_ptr_inc;
              if (!r_sda_s2) begin
                r_tx        <= r_mem[w_ptr_inc];
                r_rd_strobe <= 1'b1;
                r_state     <= S_RDDATA;
              end else begin
                r_state <= S_WAITSTOP;
                r_busy  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master plus an array model of the
// EEPROM contents and address pointer; directed cases then random transactions.
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;
  localparam int Q = 6;  // CLK cycles per quarter SCL period

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DBG_ADDR = '0;
  logic [7:0] DBG_DATA;
  logic [3:0] PTR;
  logic       BUSY, WR_STROBE, RD_STROBE;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;

  i2c_eeprom_slave_if bus();
  assign bus.SCL    = m_scl;
  assign bus.SDA_IN = m_sda & ~bus.SDA_OE;

  i2c_eeprom_slave #(.DEV_ADDR(7'h50), .ADDR_BITS(4)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .DBG_ADDR(DBG_ADDR),
    .DBG_DATA(DBG_DATA), .PTR(PTR), .BUSY(BUSY),
    .WR_STROBE(WR_STROBE), .RD_STROBE(RD_STROBE)
  );

  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_cnt = 0, rd_cnt = 0, oe_hi_cnt = 0, oe_viol = 0;
  logic oe_prev = 1'b0;
  logic [7:0] model_mem [16];
  int   mptr = 0;
  logic [7:0] wq [$];

  always @(negedge CLK) begin
    if (WR_STROBE === 1'b1) wr_cnt <= wr_cnt + 1;
    if (RD_STROBE === 1'b1) rd_cnt <= rd_cnt + 1;
    if (bus.SDA_OE === 1'b1) oe_hi_cnt <= oe_hi_cnt + 1;
    if (bus.SDA_OE !== oe_prev && m_scl) oe_viol <= oe_viol + 1;
    oe_prev <= bus.SDA_OE;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge CLK);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qwait();
    m_scl = 1'b1; qwait();
    m_sda = 1'b1; qwait();
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_sda = b;    qwait();
    m_scl = 1'b1; qwait();
    s = bus.SDA_IN; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic ack_wire);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(~mack, s);
    ack_wire = s;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      DBG_ADDR = 4'(a);
      #1;
      check_val(tag, {24'd0, DBG_DATA}, {24'd0, model_mem[a]});
    end
  endtask

  // Writes the bytes queued in wq; a non-matching control byte expects silence.
  task automatic txn_write(input logic [7:0] ctl, input logic [7:0] word);
    logic ack, exp_ack;
    int   w0, o0, n;
    w0 = wr_cnt; o0 = oe_hi_cnt; n = wq.size();
    exp_ack = (ctl[7:1] == 7'h50);
    i2c_start();
    write_byte(ctl, ack);   check_val("wr_ctl_ack", ack, exp_ack);
    check_val("wr_busy", BUSY, exp_ack);
    write_byte(word, ack);  check_val("wr_word_ack", ack, exp_ack);
    if (exp_ack) mptr = int'(word[7:4]);
    for (int k = 0; k < n; k++) begin
      write_byte(wq[k], ack);
      check_val("wr_data_ack", ack, exp_ack);
      if (exp_ack) begin
        model_mem[mptr] = wq[k];
        mptr = (mptr + 1) % 16;
      end
    end
    i2c_stop();
    qwait();
    check_val("wr_strobes", wr_cnt - w0, exp_ack ? n : 0);
    check_val("wr_ptr", PTR, mptr);
    check_val("wr_busy_end", BUSY, 0);
    if (!exp_ack) check_val("nomatch_oe", oe_hi_cnt - o0, 0);
    $display("txn write ctl=%02h word=%02h bytes=%0d ptr=%0d", ctl, word, n, PTR);
  endtask

  task automatic txn_read(input logic rnd, input logic [7:0] word, input int n);
    logic ack, s;
    logic [7:0] d;
    int r0;
    r0 = rd_cnt;
    i2c_start();
    if (rnd) begin
      write_byte(8'hA0, ack); check_val("rd_wctl_ack", ack, 1);
      write_byte(word, ack);  check_val("rd_word_ack", ack, 1);
      mptr = int'(word[7:4]);
      i2c_start();
    end
    write_byte(8'hA1, ack); check_val("rd_ctl_ack", ack, 1);
    for (int k = 0; k < n; k++) begin
      read_byte(k != n - 1, d, s);
      check_val("rd_data", d, model_mem[mptr]);
      mptr = (mptr + 1) % 16;
      if (k == n - 1) check_val("rd_nack_released", s, 1);
    end
    check_val("rd_busy_after_nack", BUSY, 0);
    i2c_stop();
    qwait();
    check_val("rd_strobes", rd_cnt - r0, n);
    check_val("rd_ptr", PTR, mptr);
    $display("txn read rnd=%0d word=%02h bytes=%0d ptr=%0d", rnd, word, n, PTR);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       s, ack;
    logic [6:0] a7;
    int         kind, n, o0;

    for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    repeat (4) @(negedge CLK);
    check_val("rst_oe", bus.SDA_OE, 0);
    check_val("rst_ptr", PTR, 0);
    check_val("rst_busy", BUSY, 0);
    check_val("rst_wstb", WR_STROBE, 0);
    check_val("rst_rstb", RD_STROBE, 0);
    check_mem("rst_mem");

    // Byte write
    wq.delete(); wq.push_back(8'h5A);
    txn_write(8'hA0, 8'h30);
    DBG_ADDR = 4'd3; #1;
    check_val("t1_mem3", DBG_DATA, 8'h5A);
    check_val("t1_ptr", PTR, 4);

    // Random read with master NACK
    txn_read(1'b1, 8'h30, 1);
    check_val("t2_ptr", PTR, 4);

    // Address mismatch
    wq.delete(); wq.push_back(8'h77);
    txn_write(8'hA4, 8'h30);
    check_mem("t3_mem");

    // Pointer wrap
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    txn_write(8'hA0, 8'hF0);
    DBG_ADDR = 4'd15; #1; check_val("t4_mem15", DBG_DATA, 8'h11);
    DBG_ADDR = 4'd0;  #1; check_val("t4_mem0", DBG_DATA, 8'h22);
    check_val("t4_ptr", PTR, 1);

    // Sequential current-address read from 14
    wq.delete();
    txn_write(8'hA0, 8'hE0);
    txn_read(1'b0, 8'h00, 3);
    check_val("t5_ptr", PTR, 1);

    for (int t = 0; t < 24; t++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          wq.delete();
          n = int'($urandom_range(1, 4));
          repeat (n) wq.push_back(8'($urandom));
          txn_write(8'hA0, 8'($urandom));
        end
        1: txn_read(1'b1, 8'($urandom), int'($urandom_range(1, 4)));
        2: txn_read(1'b0, 8'h00, int'($urandom_range(1, 3)));
        default: begin
          a7 = 7'($urandom_range(0, 127));
          if (a7 == 7'h50) a7 = 7'h51;
          wq.delete();
          wq.push_back(8'($urandom));
          txn_write({a7, 1'($urandom)}, 8'($urandom));
        end
      endcase
    end
    check_mem("rand_mem");

    // Reset during a read while bit 3 (a zero) is being driven
    wq.delete(); wq.push_back(8'hF0);
    txn_write(8'hA0, 8'h50);
    i2c_start();
    write_byte(8'hA0, ack); check_val("t6_ctl_ack", ack, 1);
    write_byte(8'h50, ack); check_val("t6_word_ack", ack, 1);
    i2c_start();
    write_byte(8'hA1, ack); check_val("t6_rctl_ack", ack, 1);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, s);
      check_val("t6_hi_bits", s, 1);
    end
    check_val("t6_oe_before", bus.SDA_OE, 1);
    #2 RESET = 1'b1;
    #1;
    check_val("t6_oe_async", bus.SDA_OE, 0);
    check_val("t6_busy", BUSY, 0);
    check_val("t6_ptr", PTR, 0);
    for (int a = 0; a < 16; a++) model_mem[a] = 8'h00;
    mptr = 0;
    check_mem("t6_mem");
    @(negedge CLK);
    RESET = 1'b0;
    o0 = oe_hi_cnt;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, s);
      check_val("t6_released", s, 1);
    end
    i2c_stop();
    qwait();
    check_val("t6_no_drive", oe_hi_cnt - o0, 0);
    $display("txn reset-mid-read ptr=%0d busy=%0d", PTR, BUSY);

    wq.delete(); wq.push_back(8'hC3); wq.push_back(8'h3C);
    txn_write(8'hA0, 8'h70);
    txn_read(1'b1, 8'h70, 2);
    check_mem("final_mem");
    check_val("oe_scl_high", oe_viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
